memory_controller: RTL and testbench



---
 rtl/memory_controller_pkg.sv | 35 +++
 rtl/memory_controller.sv | 131 +++++++++++++
 tb/tb_memory_controller.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_controller_pkg.sv
// Shared definitions for the CPU-side memory arbiter: FSM states and the
// external bus command / MemoryIOBus operation encodings.
package memory_controller_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_REQ = 3'd1,
    READ_REQ  = 3'd2,
    WRITE_REQ = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [2:0] DRIVE_IDLE  = 3'b000;
  localparam logic [2:0] DRIVE_READ  = 3'b001;
  localparam logic [2:0] DRIVE_WRITE = 3'b010;
  localparam logic [2:0] DRIVE_FETCH = 3'b100;

  localparam logic [1:0] IO_IDLE  = 2'b00;
  localparam logic [1:0] IO_READ  = 2'b01;
  localparam logic [1:0] IO_WRITE = 2'b10;

  // Bus command presented while sitting in a request state; idle elsewhere.
  function automatic logic [2:0] reqDrive(input state_t s);
    logic [2:0] code;
    code = DRIVE_IDLE;
    case (s)
      FETCH_REQ: code = DRIVE_FETCH;
      READ_REQ:  code = DRIVE_READ;
      WRITE_REQ: code = DRIVE_WRITE;
      default:   code = DRIVE_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/memory_controller.sv
// Arbitrates PC fetches and ALU load/stores onto one external bus; data ops win ties.
// Request edge -> REQ, ready edge -> DONE (2 edges minimum); waits forever on ready, holds DONE until request drops.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire  [DW-1:0] ExternalDataBus,
  inout  wire  [AW-1:0] ExternalAddressBus,
  output logic [DW-1:0] InstructionBus,
  input  logic [AW-1:0] PCAddressBus,
  input  logic          PCGetNewInstruction,
  inout  wire  [DW-1:0] InternalDataBus,
  input  logic [AW-1:0] ALUAddressBus,
  input  logic [1:0]    MemoryIOBus,
  output logic          ValidMemoryData,
  output logic [2:0]    ExternalDrive,
  input  logic          ExternalExchangeReady
);

  state_t        state;
  state_t        nextState;
  logic [AW-1:0] latchedAddr;
  logic [DW-1:0] storeData;
  logic [DW-1:0] readData;
  logic [2:0]    opCode;
  logic          addrEn;
  logic          extDataEn;
  logic          intDataEn;
  logic          requestHeld;
  logic          accept;
  logic [2:0]    driveNext;
  logic          validNext;
  logic          addrEnNext;
  logic          extDataEnNext;
  logic          intDataEnNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState     = state;
    requestHeld   = 1'b0;
    case (opCode)
      DRIVE_FETCH: requestHeld = PCGetNewInstruction;
      DRIVE_READ:  requestHeld = (MemoryIOBus == IO_READ);
      DRIVE_WRITE: requestHeld = (MemoryIOBus == IO_WRITE);
      default:     requestHeld = 1'b0;
    endcase

    case (state)
      IDLE: begin
        if (MemoryIOBus == IO_READ) begin
          nextState = READ_REQ;
        end else if (MemoryIOBus == IO_WRITE) begin
          nextState = WRITE_REQ;
        end else if (PCGetNewInstruction) begin
          nextState = FETCH_REQ;
        end
      end
      FETCH_REQ, READ_REQ, WRITE_REQ: begin
        if (ExternalExchangeReady) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (!requestHeld) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they are pure Moore.
    accept        = (state == IDLE) && (nextState != IDLE);
    driveNext     = reqDrive(nextState);
    validNext     = (nextState == DONE);
    addrEnNext    = (driveNext != DRIVE_IDLE);
    extDataEnNext = (nextState == WRITE_REQ);
    intDataEnNext = (nextState == DONE) && (opCode == DRIVE_READ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ExternalDrive   <= DRIVE_IDLE;
      ValidMemoryData <= 1'b0;
      addrEn          <= 1'b0;
      extDataEn       <= 1'b0;
      intDataEn       <= 1'b0;
      opCode          <= DRIVE_IDLE;
      latchedAddr     <= '0;
      storeData       <= '0;
      readData        <= '0;
      InstructionBus  <= '0;
    end else begin
      ExternalDrive   <= driveNext;
      ValidMemoryData <= validNext;
      addrEn          <= addrEnNext;
      extDataEn       <= extDataEnNext;
      intDataEn       <= intDataEnNext;

      if (accept) begin
        opCode      <= driveNext;
        latchedAddr <= (nextState == FETCH_REQ) ? PCAddressBus : ALUAddressBus;
        if (nextState == WRITE_REQ) begin
          storeData <= InternalDataBus;
        end
      end

      if (ExternalExchangeReady && (state == FETCH_REQ)) begin
        InstructionBus <= ExternalDataBus;
      end
      if (ExternalExchangeReady && (state == READ_REQ)) begin
        readData <= ExternalDataBus;
      end
    end
  end

  assign ExternalAddressBus = addrEn    ? latchedAddr : {AW{1'bz}};
  assign ExternalDataBus    = extDataEn ? storeData   : {DW{1'bz}};
  assign InternalDataBus    = intDataEn ? readData    : {DW{1'bz}};

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller; a scoreboard queue holds expected completions
// and a negedge monitor checks each one as ValidMemoryData rises.
module tb_memory_controller;
  import memory_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instructionBus;
  logic [31:0] pcAddr;
  logic        pcGet;
  logic [31:0] aluAddr;
  logic [1:0]  memIo;
  logic        valid;
  logic [2:0]  drive;
  logic        ready;

  wire  [31:0] extData;
  wire  [31:0] extAddr;
  wire  [31:0] intData;
  logic [31:0] edbVal, eabVal, idbVal;
  logic        edbOn, eabOn, idbOn;

  assign extData = edbOn ? edbVal : 'z;
  assign extAddr = eabOn ? eabVal : 'z;
  assign intData = idbOn ? idbVal : 'z;

  always #5 clk = ~clk;

  memory_controller #(.DW(32), .AW(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ExternalDataBus      (extData),
    .ExternalAddressBus   (extAddr),
    .InstructionBus       (instructionBus),
    .PCAddressBus         (pcAddr),
    .PCGetNewInstruction  (pcGet),
    .InternalDataBus      (intData),
    .ALUAddressBus        (aluAddr),
    .MemoryIOBus          (memIo),
    .ValidMemoryData      (valid),
    .ExternalDrive        (drive),
    .ExternalExchangeReady(ready)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // All three bidirectional buses must be released: a zero driven from the bench must read back as zero.
  task automatic checkFloat(input string name);
    logic [31:0] sE, sA, sI;
    logic        oE, oA, oI;
    sE = edbVal; sA = eabVal; sI = idbVal;
    oE = edbOn;  oA = eabOn;  oI = idbOn;
    edbVal = '0; eabVal = '0; idbVal = '0;
    edbOn = 1'b1; eabOn = 1'b1; idbOn = 1'b1;
    #1;
    check({name, " ext data released"}, extData, 32'h0);
    check({name, " ext addr released"}, extAddr, 32'h0);
    check({name, " int data released"}, intData, 32'h0);
    edbVal = sE; eabVal = sA; idbVal = sI;
    edbOn = oE;  eabOn = oA;  idbOn = oI;
  endtask

  task automatic waitValid(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (valid !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " valid reached"}, 32'(valid), 32'(lvl));
  endtask

  logic        validPrev = 1'b0;
  logic [2:0]  lastCmd = DRIVE_IDLE;
  logic [31:0] lastAddr = '0;
  logic [31:0] lastEdb = '0;
  exp_t        sbExp;

  always @(negedge clk) begin
    if (drive != DRIVE_IDLE) begin
      lastCmd  = drive;
      lastAddr = extAddr;
      lastEdb  = extData;
    end
    if (valid && !validPrev) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb unexpected completion: got cmd %0h expected none", lastCmd);
      end else begin
        sbExp = expQ.pop_front();
        check("sb cmd", 32'(lastCmd), 32'(sbExp.cmd));
        check("sb addr", lastAddr, sbExp.addr);
        check("sb drive in DONE", 32'(drive), 32'(DRIVE_IDLE));
        case (sbExp.cmd)
          DRIVE_FETCH: check("sb instruction", instructionBus, sbExp.data);
          DRIVE_READ:  check("sb load data", intData, sbExp.data);
          default:     check("sb store data", lastEdb, sbExp.data);
        endcase
      end
    end
    validPrev = valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pcGet = 1'b0; memIo = IO_IDLE; ready = 1'b0;
    pcAddr = '0; aluAddr = '0;
    edbOn = 1'b0; eabOn = 1'b0; idbOn = 1'b0;
    edbVal = '0; eabVal = '0; idbVal = '0;
    repeat (2) @(negedge clk);
    check("reset drive", 32'(drive), 32'(DRIVE_IDLE));
    check("reset valid", 32'(valid), 32'h0);
    check("reset instruction", instructionBus, 32'h0);
    checkFloat("reset");
    rst = 1'b0;
    @(negedge clk);

    // Fetch with ready delayed six cycles
    pcAddr = 32'd540; pcGet = 1'b1;
    expQ.push_back('{cmd: DRIVE_FETCH, addr: 32'd540, data: 32'd339});
    repeat (6) begin
      @(negedge clk);
      check("fetch wait addr", extAddr, 32'd540);
      check("fetch wait drive", 32'(drive), 32'(DRIVE_FETCH));
      check("fetch wait valid", 32'(valid), 32'h0);
    end
    edbOn = 1'b1; edbVal = 32'd339; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0; edbOn = 1'b0;
    waitValid(1'b1, 4, "fetch done");
    repeat (2) @(negedge clk);
    check("fetch valid held", 32'(valid), 32'h1);
    checkFloat("fetch done");
    pcGet = 1'b0;
    @(negedge clk);
    check("fetch released valid", 32'(valid), 32'h0);
    check("fetch instruction holds", instructionBus, 32'd339);

    // Read
    aluAddr = 32'd4467; memIo = IO_READ;
    expQ.push_back('{cmd: DRIVE_READ, addr: 32'd4467, data: 32'd555});
    repeat (2) begin
      @(negedge clk);
      check("read wait drive", 32'(drive), 32'(DRIVE_READ));
    end
    edbOn = 1'b1; edbVal = 32'd555; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0; edbOn = 1'b0;
    waitValid(1'b1, 4, "read done");
    check("read int data", intData, 32'd555);
    memIo = IO_IDLE;
    @(negedge clk);
    check("read released valid", 32'(valid), 32'h0);
    checkFloat("after read");

    // Write; request inputs change after acceptance and must be ignored
    aluAddr = 32'd4467; memIo = IO_WRITE; idbOn = 1'b1; idbVal = 32'd555;
    expQ.push_back('{cmd: DRIVE_WRITE, addr: 32'd4467, data: 32'd555});
    @(negedge clk);
    check("write drive", 32'(drive), 32'(DRIVE_WRITE));
    idbVal = 32'hdead; aluAddr = 32'd1;
    @(negedge clk);
    check("write ext data latched", extData, 32'd555);
    check("write ext addr latched", extAddr, 32'd4467);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    waitValid(1'b1, 4, "write done");
    checkFloat("write done");
    memIo = IO_IDLE; idbOn = 1'b0;
    @(negedge clk);
    check("write released valid", 32'(valid), 32'h0);

    // Contention: data op served before fetch
    pcAddr = 32'h100; pcGet = 1'b1; aluAddr = 32'h200; memIo = IO_READ;
    expQ.push_back('{cmd: DRIVE_READ, addr: 32'h200, data: 32'haaaa});
    expQ.push_back('{cmd: DRIVE_FETCH, addr: 32'h100, data: 32'hbbbb});
    @(negedge clk);
    check("contention first drive", 32'(drive), 32'(DRIVE_READ));
    edbOn = 1'b1; edbVal = 32'haaaa; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    waitValid(1'b1, 4, "contention read");
    memIo = IO_IDLE;
    waitValid(1'b0, 4, "contention read release");
    edbVal = 32'hbbbb; ready = 1'b1;
    waitValid(1'b1, 6, "contention fetch");
    ready = 1'b0; edbOn = 1'b0; pcGet = 1'b0;
    @(negedge clk);
    check("contention released valid", 32'(valid), 32'h0);

    // Reset aborts an outstanding fetch
    pcAddr = 32'h300; pcGet = 1'b1;
    repeat (2) @(negedge clk);
    check("abort pre drive", 32'(drive), 32'(DRIVE_FETCH));
    check("abort pre addr", extAddr, 32'h300);
    rst = 1'b1;
    #2;
    check("abort drive", 32'(drive), 32'(DRIVE_IDLE));
    check("abort valid", 32'(valid), 32'h0);
    check("abort instruction", instructionBus, 32'h0);
    checkFloat("abort");
    pcGet = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Ready held high: each fetch completes two edges after its request
    ready = 1'b1; edbOn = 1'b1; edbVal = 32'h7777;
    @(negedge clk);
    check("ready-high idle drive", 32'(drive), 32'(DRIVE_IDLE));
    pcAddr = 32'h400; pcGet = 1'b1;
    expQ.push_back('{cmd: DRIVE_FETCH, addr: 32'h400, data: 32'h7777});
    @(negedge clk);
    check("fast fetch edge1 valid", 32'(valid), 32'h0);
    check("fast fetch edge1 drive", 32'(drive), 32'(DRIVE_FETCH));
    @(negedge clk);
    check("fast fetch edge2 valid", 32'(valid), 32'h1);
    pcGet = 1'b0;
    @(negedge clk);
    check("fast fetch release", 32'(valid), 32'h0);
    pcAddr = 32'h404; pcGet = 1'b1; edbVal = 32'h8888;
    expQ.push_back('{cmd: DRIVE_FETCH, addr: 32'h404, data: 32'h8888});
    @(negedge clk);
    check("second fast fetch edge1 valid", 32'(valid), 32'h0);
    @(negedge clk);
    check("second fast fetch edge2 valid", 32'(valid), 32'h1);
    pcGet = 1'b0; ready = 1'b0; edbOn = 1'b0;
    repeat (2) @(negedge clk);

    check("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
